// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types for the LED counter run controller.
//   run_state_e : IDLE / RUN / PAUSE / DONE controller states
//   DIR_UP/DIR_DN : encoding of the count direction bit
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/counter_step.sv
// counter_step: combinational next-count calculation for one TICK.
//   count      in  current count
//   dir        in  DIR_UP / DIR_DN
//   one_shot   in  1 = hold at terminal, 0 = wrap (or bounce)
//   pingpong   in  1 = bounce off the terminal instead of wrapping
//   next_count out value COUNT takes on this TICK
//   at_term    out count sits on the terminal for the current direction
//   wrap       out this step wraps or bounces
module counter_step
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             one_shot,
  input  logic             pingpong,
  output logic [WIDTH-1:0] next_count,
  output logic             at_term,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    // >= keeps the up-wrap explicit at MAX even when MAX < 2^WIDTH-1
    at_term    = (dir == DIR_DN) ? (count == '0) : (count >= MAX);
    wrap       = 1'b0;
    next_count = (dir == DIR_DN) ? count - ONE : count + ONE;
    if (at_term) begin
      if (one_shot) begin
        next_count = count;
      end else if (pingpong) begin
        next_count = (dir == DIR_DN) ? ONE : MAX - ONE;
        wrap       = 1'b1;
      end else begin
        next_count = (dir == DIR_DN) ? MAX : '0;
        wrap       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run/stop/direction controller for the LED counter.
// Optional feature: define CNT_PINGPONG_EN to add the PINGPONG port
// (bounce at the terminals instead of wrapping).
//   CLK       in  board clock
//   RST       in  synchronous active-high reset
//   TICK      in  step enable from the divider
//   START     in  run / resume request (level)
//   STOP      in  pause request (level, beats START)
//   DIR       in  0 = up, 1 = down
//   ONE_SHOT  in  1 = halt at terminal, 0 = wrap
//   LOAD      in  preset strobe, LOAD_VAL clamped to MAX_VAL
//   LOAD_VAL  in  preset value
//   PINGPONG  in  bounce mode (CNT_PINGPONG_EN only)
//   COUNT     out registered count
//   LED       out active-low LED bus, ~COUNT
//   RUNNING   out high in RUN
//   DONE      out high in DONE
//   WRAP      out one-cycle pulse on wrap / bounce
module counter_run_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             START,
  input  logic             STOP,
  input  logic             DIR,
  input  logic             ONE_SHOT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
`ifdef CNT_PINGPONG_EN
  input  logic             PINGPONG,
`endif
  output logic [WIDTH-1:0] COUNT,
  output logic [WIDTH-1:0] LED,
  output logic             RUNNING,
  output logic             DONE,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  run_state_e       state;
  logic [WIDTH-1:0] count_q;
  logic             dir_q;
  logic             running_q;
  logic             done_q;
  logic             wrap_q;

  logic             pp_in;
  logic             pp_mode;
  logic [WIDTH-1:0] next_count;
  logic             at_term;
  logic             step_wrap;

`ifdef CNT_PINGPONG_EN
  assign pp_in = PINGPONG;
`else
  assign pp_in = 1'b0;
`endif
  // one-shot overrides bouncing
  assign pp_mode = pp_in & ~ONE_SHOT;

  counter_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_step (
    .count      (count_q),
    .dir        (dir_q),
    .one_shot   (ONE_SHOT),
    .pingpong   (pp_mode),
    .next_count (next_count),
    .at_term    (at_term),
    .wrap       (step_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      count_q   <= '0;
      dir_q     <= DIR_UP;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (LOAD) begin
        // LOAD swallows STOP/START/TICK of the same cycle
        count_q <= (LOAD_VAL > MAX) ? MAX : LOAD_VAL;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (START && !STOP) begin
              state     <= RUN;
              dir_q     <= DIR;
              running_q <= 1'b1;
            end
          end
          counter_ctrl_pkg::DONE: begin
            if (START && !STOP) begin
              state     <= RUN;
              dir_q     <= DIR;
              count_q   <= (DIR == DIR_DN) ? MAX : '0;
              running_q <= 1'b1;
              done_q    <= 1'b0;
            end
          end
          RUN: begin
            if (STOP) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end else if (TICK) begin
              count_q <= next_count;
              wrap_q  <= step_wrap;
              if (ONE_SHOT && at_term) begin
                state     <= counter_ctrl_pkg::DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
              // bounce mode owns the direction while running
              if (pp_mode) begin
                if (at_term) dir_q <= ~dir_q;
              end else begin
                dir_q <= DIR;
              end
            end
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign COUNT   = count_q;
  assign LED     = ~count_q;
  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign WRAP    = wrap_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: two controllers (MAX_VAL 15 and 10) on one stimulus
// stream, checked every cycle against an integer model plus directed
// literal expectations.
module tb_counter_run_ctrl;
  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TICK = 1'b0, START = 1'b0, STOP = 1'b0, DIR = 1'b0;
  logic ONE_SHOT = 1'b0, LOAD = 1'b0, PINGPONG = 1'b0;
  logic [W-1:0] LOAD_VAL = '0;

  logic [W-1:0] cnt0, led0, cnt1, led1;
  logic run0, done0, wrap0, run1, done1, wrap1;

  int checks = 0;
  int errors = 0;

  // model: states 0 idle, 1 run, 2 pause, 3 done
  int m_st[2]   = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_dir[2]  = '{0, 0};
  int m_wrap[2] = '{0, 0};
  int mx[2]     = '{15, 10};

  always #5 CLK = ~CLK;

  counter_run_ctrl #(.WIDTH(W), .MAX_VAL(15)) dut0 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .STOP(STOP),
    .DIR(DIR), .ONE_SHOT(ONE_SHOT), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
`ifdef CNT_PINGPONG_EN
    .PINGPONG(PINGPONG),
`endif
    .COUNT(cnt0), .LED(led0), .RUNNING(run0), .DONE(done0), .WRAP(wrap0)
  );

  counter_run_ctrl #(.WIDTH(W), .MAX_VAL(10)) dut1 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .STOP(STOP),
    .DIR(DIR), .ONE_SHOT(ONE_SHOT), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
`ifdef CNT_PINGPONG_EN
    .PINGPONG(PINGPONG),
`endif
    .COUNT(cnt1), .LED(led1), .RUNNING(run1), .DONE(done1), .WRAP(wrap1)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model, evaluated from the rules on integers
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      int  term;
      bit  pp;
      m_wrap[k] = 0;
      if (RST) begin
        m_st[k] = 0; m_cnt[k] = 0; m_dir[k] = 0;
      end else if (LOAD) begin
        m_cnt[k] = (int'(LOAD_VAL) > mx[k]) ? mx[k] : int'(LOAD_VAL);
      end else if (m_st[k] != 1) begin
        if (START && !STOP) begin
          if (m_st[k] == 3) m_cnt[k] = DIR ? mx[k] : 0;
          m_st[k] = 1;
          m_dir[k] = int'(DIR);
        end
      end else if (STOP) begin
        m_st[k] = 2;
      end else if (TICK) begin
        pp   = PINGPONG && !ONE_SHOT;
        term = (m_dir[k] != 0) ? 0 : mx[k];
        if (m_cnt[k] == term && ONE_SHOT) begin
          m_st[k] = 3;
        end else if (m_cnt[k] == term && pp) begin
          m_cnt[k]  = (m_dir[k] != 0) ? 1 : mx[k] - 1;
          m_wrap[k] = 1;
          m_dir[k]  = (m_dir[k] != 0) ? 0 : 1;
        end else begin
          m_cnt[k] = m_cnt[k] + ((m_dir[k] != 0) ? -1 : 1);
          if (m_cnt[k] > mx[k]) begin m_cnt[k] = 0; m_wrap[k] = 1; end
          else if (m_cnt[k] < 0) begin m_cnt[k] = mx[k]; m_wrap[k] = 1; end
        end
        if (!pp) m_dir[k] = int'(DIR);
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge CLK) begin
    cmp("count0", 32'(cnt0), 32'(m_cnt[0]));
    cmp("led0",   32'(led0), 32'(15 - m_cnt[0]));
    cmp("run0",   32'(run0), 32'(m_st[0] == 1));
    cmp("done0",  32'(done0), 32'(m_st[0] == 3));
    cmp("wrap0",  32'(wrap0), 32'(m_wrap[0]));
    cmp("count1", 32'(cnt1), 32'(m_cnt[1]));
    cmp("led1",   32'(led1), 32'(15 - m_cnt[1]));
    cmp("run1",   32'(run1), 32'(m_st[1] == 1));
    cmp("done1",  32'(done1), 32'(m_st[1] == 3));
    cmp("wrap1",  32'(wrap1), 32'(m_wrap[1]));
  end

  task automatic cyc(input bit t, input bit s, input bit p, input bit l);
    TICK = t; START = s; STOP = p; LOAD = l;
    @(posedge CLK);
    @(negedge CLK);
    TICK = 0; START = 0; STOP = 0; LOAD = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc(0, 0, 0, 0);
    RST = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    cmp("rst_count", 32'(cnt0), 0);
    cmp("rst_led",   32'(led0), 15);
    cmp("rst_run",   32'(run0), 0);
    cmp("rst_done",  32'(done0), 0);
    cmp("rst_wrap",  32'(wrap0), 0);

    // up count with wrap
    DIR = 0; ONE_SHOT = 0;
    cyc(0, 1, 0, 0);
    cmp("t1_running", 32'(run0), 1);
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 0, 0, 0);
      cmp("t1_count", 32'(cnt0), 32'(i % 16));
      cmp("t1_wrap",  32'(wrap0), 32'(i == 16));
    end
    cmp("t1_model_cnt0", 32'(m_cnt[0]), 1);
    cmp("t1_cnt1", 32'(cnt1), 6);

    // one-shot down to DONE, then reload
    do_reset();
    DIR = 1; ONE_SHOT = 1; LOAD_VAL = 4'd2;
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); cmp("t2_c1", 32'(cnt0), 1);
    cyc(1, 0, 0, 0); cmp("t2_c2", 32'(cnt0), 0); cmp("t2_nodone", 32'(done0), 0);
    cyc(1, 0, 0, 0); cmp("t2_c3", 32'(cnt0), 0); cmp("t2_done", 32'(done0), 1);
    cmp("t2_model_st", 32'(m_st[0]), 3);
    cyc(1, 0, 0, 0); cmp("t2_c4", 32'(cnt0), 0); cmp("t2_done4", 32'(done0), 1);
    cyc(0, 1, 0, 0);
    cmp("t2_reload", 32'(cnt0), 15); cmp("t2_reload1", 32'(cnt1), 10);
    cmp("t2_rerun", 32'(run0), 1);

    // STOP beats TICK, STOP beats START, START from PAUSE drops TICK
    LOAD_VAL = 4'd5;
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 0);
    cmp("t3_pause_cnt", 32'(cnt0), 5); cmp("t3_pause_run", 32'(run0), 0);
    cyc(0, 1, 1, 0);
    cmp("t3_startstop", 32'(run0), 0);
    cyc(1, 1, 0, 0);
    cmp("t3_resume_run", 32'(run0), 1); cmp("t3_resume_cnt", 32'(cnt0), 5);
    cyc(1, 0, 0, 0);
    cmp("t3_step", 32'(cnt0), 4);

    // LOAD beats TICK; clamp
    LOAD_VAL = 4'd9;
    cyc(1, 0, 0, 1);
    cmp("t4_load", 32'(cnt0), 9); cmp("t4_run", 32'(run0), 1);
    LOAD_VAL = 4'd15;
    cyc(0, 0, 0, 1);
    cmp("t4_load15", 32'(cnt0), 15); cmp("t4_clamp", 32'(cnt1), 10);

    // reset mid-run with a tick pending
    DIR = 0; ONE_SHOT = 0; LOAD_VAL = 4'd7;
    cyc(0, 0, 0, 1);
    cmp("t5_pre", 32'(cnt0), 7);
    RST = 1'b1;
    cyc(1, 0, 0, 0);
    RST = 1'b0;
    cmp("t5_cnt", 32'(cnt0), 0); cmp("t5_led", 32'(led0), 15);
    cmp("t5_run", 32'(run0), 0); cmp("t5_wrap", 32'(wrap0), 0);

    // down wrap 0 -> MAX
    DIR = 1; ONE_SHOT = 0;
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cmp("t6_cnt", 32'(cnt0), 15); cmp("t6_wrap", 32'(wrap0), 1); cmp("t6_cnt1", 32'(cnt1), 10);
    cyc(1, 0, 0, 0);
    cmp("t6_cnt2", 32'(cnt0), 14); cmp("t6_wrap2", 32'(wrap0), 0);

`ifdef CNT_PINGPONG_EN
    // bounce at MAX
    do_reset();
    PINGPONG = 1; DIR = 0; ONE_SHOT = 0; LOAD_VAL = 4'd14;
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); cmp("pp_c1", 32'(cnt0), 15); cmp("pp_w1", 32'(wrap0), 0);
    cyc(1, 0, 0, 0); cmp("pp_c2", 32'(cnt0), 14); cmp("pp_w2", 32'(wrap0), 1);
    cyc(1, 0, 0, 0); cmp("pp_c3", 32'(cnt0), 13); cmp("pp_w3", 32'(wrap0), 0);
    cyc(1, 0, 0, 0); cmp("pp_c4", 32'(cnt0), 12);
    PINGPONG = 0;
`endif

    cyc(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
